// File: rtl/counter_pkg.sv
// Shared definitions for the counter family: end-of-range mode and a load clamp
// reused by the timer blocks built on this counter.
package counter_pkg;

    typedef enum logic {
        CNT_WRAP = 1'b0,
        CNT_SAT  = 1'b1
    } cnt_mode_e;

    function automatic int unsigned cnt_clamp(input int unsigned val, input int unsigned max_val);
        return (val > max_val) ? max_val : val;
    endfunction

endpackage

// File: rtl/cnt_next_calc.sv
// Combinational next-state logic for param_updown_counter: resolves
// load > count > hold and the range-end behaviour selected by MODE.
module cnt_next_calc
    import counter_pkg::*;
#(
    parameter int          WIDTH   = 4,
    parameter int unsigned MAX_VAL = 2**WIDTH - 1,
    parameter cnt_mode_e   MODE    = CNT_WRAP
) (
    input  logic [WIDTH-1:0] q,
    input  logic             up,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q_next,
    output logic             wrap_next
);

    localparam logic [WIDTH:0]   MAX_EXT = (WIDTH+1)'(MAX_VAL);
    localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MAX_VAL);

    // One extra bit so the top-of-range test and the borrow out of zero
    // never alias with a legal count value.
    logic [WIDTH:0] inc;
    logic [WIDTH:0] dec;

    assign inc = {1'b0, q} + (WIDTH+1)'(1);
    assign dec = {1'b0, q} - (WIDTH+1)'(1);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch.
        q_next    = q;
        wrap_next = 1'b0;
        if (load) begin
            q_next = WIDTH'(cnt_clamp(32'(load_val), MAX_VAL));
        end else if (en) begin
            if (up) begin
                if (inc > MAX_EXT) begin
                    wrap_next = 1'b1;
                    q_next    = (MODE == CNT_SAT) ? MAX_Q : '0;
                end else begin
                    q_next = inc[WIDTH-1:0];
                end
            end else begin
                if (dec[WIDTH]) begin
                    wrap_next = 1'b1;
                    q_next    = (MODE == CNT_SAT) ? '0 : MAX_Q;
                end else begin
                    q_next = dec[WIDTH-1:0];
                end
            end
        end
    end

endmodule

// File: rtl/param_updown_counter_props.sv
// Concurrent checks for param_updown_counter, attached to every instance by
// the bind at the bottom of this file.
module param_updown_counter_props #(
    parameter int          WIDTH   = 4,
    parameter int unsigned MAX_VAL = 2**WIDTH - 1
) (
    input logic             clk,
    input logic             rst,
    input logic             en,
    input logic             up,
    input logic             load,
    input logic [WIDTH-1:0] q,
    input logic             tc,
    input logic             wrap
);

    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_VAL);

    a_in_range: assert property (@(posedge clk) disable iff (!rst)
        q <= MAX_Q);

    a_step_up: assert property (@(posedge clk) disable iff (!rst)
        (en && !load && up && q < MAX_Q) |=> (q == $past(q) + WIDTH'(1)));

    a_step_down: assert property (@(posedge clk) disable iff (!rst)
        (en && !load && !up && q != '0) |=> (q == $past(q) - WIDTH'(1)));

    a_wrap_cause: assert property (@(posedge clk) disable iff (!rst)
        wrap |-> $past(tc && en && !load));

endmodule

bind param_updown_counter param_updown_counter_props #(
    .WIDTH   (WIDTH),
    .MAX_VAL (MAX_VAL)
) u_props (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .up   (up),
    .load (load),
    .q    (q),
    .tc   (tc),
    .wrap (wrap)
);

// File: rtl/param_updown_counter.sv
// Parametrised up/down counter with load, wrap/saturate ends, terminal count
// and a registered range-end pulse.
module param_updown_counter
    import counter_pkg::*;
#(
    parameter int          WIDTH   = 4,
    parameter int unsigned MAX_VAL = 2**WIDTH - 1,
    parameter cnt_mode_e   MODE    = CNT_WRAP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_bar,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_VAL);

    logic [WIDTH-1:0] q_next;
    logic             wrap_next;

    cnt_next_calc #(
        .WIDTH   (WIDTH),
        .MAX_VAL (MAX_VAL),
        .MODE    (MODE)
    ) u_next (
        .q         (q),
        .up        (up),
        .en        (en),
        .load      (load),
        .load_val  (load_val),
        .q_next    (q_next),
        .wrap_next (wrap_next)
    );

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: state registers use non-blocking assignments only.
        if (!rst) begin
            q    <= '0;
            wrap <= 1'b0;
        end else begin
            q    <= q_next;
            wrap <= wrap_next;
        end
    end

    assign q_bar = ~q;
    assign tc    = up ? (q == MAX_Q) : (q == '0);

endmodule

// File: tb/tb_param_updown_counter.sv
// Drives three counter configurations (mod-16 wrap, mod-10 wrap, mod-10
// saturate) with shared stimulus and checks them against a behavioural model.
module tb_param_updown_counter;
    import counter_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       up;
    logic       load;
    logic [3:0] load_val;

    logic [3:0] dq   [3];
    logic [3:0] dqb  [3];
    logic       dtc  [3];
    logic       dwrap[3];

    int checks   = 0;
    int failures = 0;

    // Behavioural model state, one entry per instance.
    int m_q  [3];
    int m_w  [3];
    int max_v[3] = '{15, 9, 9};
    bit sat_v[3] = '{1'b0, 1'b0, 1'b1};

    always #5 clk = ~clk;

    param_updown_counter #(.WIDTH(4)) u_a (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
        .q(dq[0]), .q_bar(dqb[0]), .tc(dtc[0]), .wrap(dwrap[0])
    );

    param_updown_counter #(.WIDTH(4), .MAX_VAL(9), .MODE(CNT_WRAP)) u_b (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
        .q(dq[1]), .q_bar(dqb[1]), .tc(dtc[1]), .wrap(dwrap[1])
    );

    param_updown_counter #(.WIDTH(4), .MAX_VAL(9), .MODE(CNT_SAT)) u_c (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
        .q(dq[2]), .q_bar(dqb[2]), .tc(dtc[2]), .wrap(dwrap[2])
    );

    // Advance one clock: the model applies the counting rules to the inputs
    // present at the edge, then outputs are sampled 1 time unit later.
    task automatic step();
        int nq[3];
        int nw[3];
        for (int i = 0; i < 3; i++) begin
            nq[i] = m_q[i];
            nw[i] = 0;
            if (!rst) begin
                nq[i] = 0;
            end else if (load) begin
                nq[i] = (int'(load_val) > max_v[i]) ? max_v[i] : int'(load_val);
            end else if (en && up) begin
                if (m_q[i] == max_v[i]) begin
                    nw[i] = 1;
                    nq[i] = sat_v[i] ? max_v[i] : 0;
                end else begin
                    nq[i] = m_q[i] + 1;
                end
            end else if (en) begin
                if (m_q[i] == 0) begin
                    nw[i] = 1;
                    nq[i] = sat_v[i] ? 0 : max_v[i];
                end else begin
                    nq[i] = m_q[i] - 1;
                end
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            m_q[i] = nq[i];
            m_w[i] = nw[i];
        end
    endtask

    task automatic do_reset();
        rst = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0; load_val = '0;
        for (int i = 0; i < 3; i++) begin
            m_q[i] = 0;
            m_w[i] = 0;
        end
        step();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0; load_val = '0;
        #2;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (dq[i] !== 4'd0 || dqb[i] !== 4'hF || dwrap[i] !== 1'b0 || dtc[i] !== 1'b0) begin
                failures++;
                $display("FAIL reset_state[%0d]: q=%h q_bar=%h wrap=%b tc=%b, want 0/f/0/0",
                         i, dq[i], dqb[i], dwrap[i], dtc[i]);
            end
        end
        up = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (dtc[i] !== 1'b1) begin
                failures++;
                $display("FAIL reset_tc_down[%0d]: tc=%b, want 1", i, dtc[i]);
            end
        end
        do_reset();
    endtask

    task automatic test_count_up();
        int exp_q;
        do_reset();
        en = 1'b1; up = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            step();
            exp_q = k % 16;
            checks++;
            if (dq[0] !== 4'(exp_q) || dwrap[0] !== (k == 16) || dtc[0] !== (exp_q == 15)) begin
                failures++;
                $display("FAIL count_up step %0d: q=%0d wrap=%b tc=%b, want q=%0d wrap=%b tc=%b",
                         k, dq[0], dwrap[0], dtc[0], exp_q, (k == 16), (exp_q == 15));
            end
        end
    endtask

    task automatic test_mod10_down();
        int exp_q;
        do_reset();
        up = 1'b0;
        #1;
        checks++;
        if (dqb[1] !== 4'hF || dtc[1] !== 1'b1) begin
            failures++;
            $display("FAIL mod10_start: q_bar=%h tc=%b, want f/1", dqb[1], dtc[1]);
        end
        en = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            step();
            exp_q = (k % 10 == 0) ? 0 : 10 - (k % 10);
            checks++;
            if (dq[1] !== 4'(exp_q) || dwrap[1] !== (k % 10 == 1)) begin
                failures++;
                $display("FAIL mod10_down step %0d: q=%0d wrap=%b, want q=%0d wrap=%b",
                         k, dq[1], dwrap[1], exp_q, (k % 10 == 1));
            end
            if (k == 1) begin
                checks++;
                if (dqb[1] !== 4'h6) begin
                    failures++;
                    $display("FAIL mod10_qbar: q_bar=%h, want 6", dqb[1]);
                end
            end
        end
    endtask

    task automatic test_saturation();
        int exp_q[5] = '{8, 9, 9, 9, 9};
        bit exp_w[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        do_reset();
        load = 1'b1; load_val = 4'd7;
        step();
        load = 1'b0;
        checks++;
        if (dq[2] !== 4'd7) begin
            failures++;
            $display("FAIL sat_load7: q=%0d, want 7", dq[2]);
        end
        en = 1'b1; up = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            checks++;
            if (dq[2] !== 4'(exp_q[k]) || dwrap[2] !== exp_w[k] || dtc[2] !== (exp_q[k] == 9)) begin
                failures++;
                $display("FAIL sat_up step %0d: q=%0d wrap=%b tc=%b, want q=%0d wrap=%b",
                         k, dq[2], dwrap[2], dtc[2], exp_q[k], exp_w[k]);
            end
        end
        up = 1'b0;
        step();
        checks++;
        if (dq[2] !== 4'd8 || dwrap[2] !== 1'b0) begin
            failures++;
            $display("FAIL sat_turn_down: q=%0d wrap=%b, want 8/0", dq[2], dwrap[2]);
        end
    endtask

    task automatic test_load_priority();
        en = 1'b1; up = 1'b1; load = 1'b1; load_val = 4'd12;
        step();
        checks++;
        if (dq[0] !== 4'd12 || dq[1] !== 4'd9 || dq[2] !== 4'd9 ||
            dwrap[1] !== 1'b0 || dwrap[2] !== 1'b0) begin
            failures++;
            $display("FAIL load_clamp: q=%0d/%0d/%0d wrap=%b/%b, want 12/9/9 0/0",
                     dq[0], dq[1], dq[2], dwrap[1], dwrap[2]);
        end
        load_val = 4'd9;
        step();
        load = 1'b0;
        checks++;
        if (dq[1] !== 4'd9 || dwrap[1] !== 1'b0 || dq[0] !== 4'd9) begin
            failures++;
            $display("FAIL load_over_wrap: q=%0d/%0d wrap=%b, want 9/9 wrap 0",
                     dq[0], dq[1], dwrap[1]);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        en = 1'b1; up = 1'b1;
        repeat (6) step();
        checks++;
        if (dq[0] !== 4'd6) begin
            failures++;
            $display("FAIL async_pre: q=%0d, want 6", dq[0]);
        end
        #3;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            m_q[i] = 0;
            m_w[i] = 0;
        end
        #1;
        checks++;
        if (dq[0] !== 4'd0 || dwrap[0] !== 1'b0) begin
            failures++;
            $display("FAIL async_clear: q=%0d wrap=%b, want 0/0 before edge", dq[0], dwrap[0]);
        end
        step();
        checks++;
        if (dq[0] !== 4'd0) begin
            failures++;
            $display("FAIL async_held: q=%0d, want 0 while reset low", dq[0]);
        end
        #3;
        rst = 1'b1;
        step();
        checks++;
        if (dq[0] !== 4'd1) begin
            failures++;
            $display("FAIL async_release: q=%0d, want 1 on first edge after release", dq[0]);
        end
    endtask

    task automatic test_hold_flip();
        int exp_q[4] = '{5, 4, 5, 4};
        do_reset();
        load = 1'b1; load_val = 4'd4;
        step();
        load = 1'b0; en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            up = 1'($urandom);
            step();
            checks++;
            if (dq[0] !== 4'd4 || dwrap[0] !== 1'b0) begin
                failures++;
                $display("FAIL hold %0d: q=%0d wrap=%b, want 4/0", k, dq[0], dwrap[0]);
            end
        end
        en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            up = (k % 2 == 0);
            step();
            checks++;
            if (dq[0] !== 4'(exp_q[k]) || dwrap[0] !== 1'b0) begin
                failures++;
                $display("FAIL flip %0d: q=%0d wrap=%b, want %0d/0", k, dq[0], dwrap[0], exp_q[k]);
            end
        end
    endtask

    task automatic test_random();
        bit exp_tc;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            en       = ($urandom_range(0, 3) != 0);
            up       = 1'($urandom);
            load     = ($urandom_range(0, 9) == 0);
            load_val = 4'($urandom);
            if ($urandom_range(0, 99) == 0) begin
                rst = 1'b0;
                step();
                rst = 1'b1;
            end
            step();
            for (int i = 0; i < 3; i++) begin
                exp_tc = up ? (m_q[i] == max_v[i]) : (m_q[i] == 0);
                checks++;
                if (dq[i] !== 4'(m_q[i]) || dqb[i] !== ~4'(m_q[i]) ||
                    dwrap[i] !== 1'(m_w[i]) || dtc[i] !== exp_tc) begin
                    failures++;
                    $display("FAIL random[%0d] cyc %0d: q=%0d q_bar=%h wrap=%b tc=%b, want q=%0d wrap=%0d tc=%b",
                             i, n, dq[i], dqb[i], dwrap[i], dtc[i], m_q[i], m_w[i], exp_tc);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_mod10_down();
        test_saturation();
        test_load_priority();
        test_async_reset();
        test_hold_flip();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
